// File: rtl/gb_alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the accumulator/flag stage.
package gb_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_CP  = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_DAA = 4'hA;
    localparam logic [3:0] OP_CPL = 4'hB;
    localparam logic [3:0] OP_SCF = 4'hC;
    localparam logic [3:0] OP_CCF = 4'hD;
    localparam logic [3:0] OP_LDA = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/daa_mod.sv
// Decimal-adjust of A after a BCD add (n_in=0) or subtract (n_in=1), driven by the C/H/N flags.
module daa_mod (
    input  logic [7:0] in,
    input  logic       c_in,
    input  logic       h_in,
    input  logic       n_in,
    output logic [7:0] out,
    output logic       c_out,
    output logic       z_out
);

    logic       hi_adj;
    logic       lo_adj;
    logic [7:0] corr;

    always_comb begin
        // After a subtract only the recorded borrows say which nibbles need fixing.
        if (n_in) begin
            hi_adj = c_in;
            lo_adj = h_in;
        end else begin
            hi_adj = c_in || (in > 8'h99);
            lo_adj = h_in || (in[3:0] > 4'h9);
        end
        corr  = {1'b0, hi_adj, hi_adj, 2'b00, lo_adj, lo_adj, 1'b0};
        out   = n_in ? (in - corr) : (in + corr);
        c_out = hi_adj;
    end

    assign z_out = (out == 8'h00);

endmodule

// File: rtl/acc_flag_alu.sv
// A/F register execution stage: accepts one ALU command, executes it in a single EXEC
// cycle and writes A/F back with a one-cycle done pulse; POP AF loads bypass the ALU.
module acc_flag_alu
    import gb_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_operand,
    input  logic        load_af_valid,
    output logic        load_af_ready,
    input  logic [15:0] af_in,
    output logic [7:0]  a_out,
    output logic [7:0]  f_out,
    output logic        done
);

    state_t     state_q;
    logic [3:0] op_q;
    logic [7:0] b_q;
    logic [7:0] a_q, a_d;
    logic [7:0] f_q, f_d;
    logic       done_q;

    logic       cin;
    logic [8:0] add9, sub9;
    logic [4:0] add_h, sub_h;
    logic [7:0] r_and, r_xor, r_or;
    logic [7:0] daa_out;
    logic       daa_c, daa_z;
    logic       unused_af_low;

    assign unused_af_low = ^af_in[3:0];

    daa_mod u_daa (
        .in    (a_q),
        .c_in  (f_q[FLAG_C]),
        .h_in  (f_q[FLAG_H]),
        .n_in  (f_q[FLAG_N]),
        .out   (daa_out),
        .c_out (daa_c),
        .z_out (daa_z)
    );

    always_comb begin
        cin   = ((op_q == OP_ADC) || (op_q == OP_SBC)) ? f_q[FLAG_C] : 1'b0;
        add9  = {1'b0, a_q} + {1'b0, b_q} + {8'b0, cin};
        sub9  = {1'b0, a_q} - {1'b0, b_q} - {8'b0, cin};
        // Bit 4 of the nibble sum/difference is the half carry/borrow.
        add_h = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, cin};
        sub_h = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, cin};
        r_and = a_q & b_q;
        r_xor = a_q ^ b_q;
        r_or  = a_q | b_q;

        a_d = a_q;
        f_d = f_q;
        case (op_q)
            OP_ADD, OP_ADC: begin
                a_d = add9[7:0];
                f_d = {add9[7:0] == 8'h00, 1'b0, add_h[4], add9[8], 4'b0000};
            end
            OP_SUB, OP_SBC: begin
                a_d = sub9[7:0];
                f_d = {sub9[7:0] == 8'h00, 1'b1, sub_h[4], sub9[8], 4'b0000};
            end
            OP_CP:  f_d = {sub9[7:0] == 8'h00, 1'b1, sub_h[4], sub9[8], 4'b0000};
            OP_AND: begin
                a_d = r_and;
                f_d = {r_and == 8'h00, 1'b0, 1'b1, 1'b0, 4'b0000};
            end
            OP_XOR: begin
                a_d = r_xor;
                f_d = {r_xor == 8'h00, 3'b000, 4'b0000};
            end
            OP_OR: begin
                a_d = r_or;
                f_d = {r_or == 8'h00, 3'b000, 4'b0000};
            end
            OP_INC: begin
                a_d = a_q + 8'd1;
                f_d = {a_q == 8'hFF, 1'b0, a_q[3:0] == 4'hF, f_q[FLAG_C], 4'b0000};
            end
            OP_DEC: begin
                a_d = a_q - 8'd1;
                f_d = {a_q == 8'h01, 1'b1, a_q[3:0] == 4'h0, f_q[FLAG_C], 4'b0000};
            end
            OP_DAA: begin
                a_d = daa_out;
                f_d = {daa_z, f_q[FLAG_N], 1'b0, daa_c, 4'b0000};
            end
            OP_CPL: begin
                a_d = ~a_q;
                f_d = {f_q[FLAG_Z], 1'b1, 1'b1, f_q[FLAG_C], 4'b0000};
            end
            OP_SCF: f_d = {f_q[FLAG_Z], 1'b0, 1'b0, 1'b1, 4'b0000};
            OP_CCF: f_d = {f_q[FLAG_Z], 1'b0, 1'b0, ~f_q[FLAG_C], 4'b0000};
            OP_LDA: a_d = b_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            b_q     <= 8'h00;
            a_q     <= 8'h00;
            f_q     <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A pending AF load always beats a command offered in the same cycle.
                    if (load_af_valid) begin
                        a_q <= af_in[15:8];
                        f_q <= {af_in[7:4], 4'b0000};
                    end else if (cmd_valid) begin
                        op_q    <= cmd_op;
                        b_q     <= cmd_operand;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    a_q     <= a_d;
                    f_q     <= f_d;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE) && !load_af_valid;
    assign load_af_ready = (state_q == ST_IDLE);
    assign a_out         = a_q;
    assign f_out         = f_q;
    assign done          = done_q;

endmodule

// File: tb/tb_acc_flag_alu.sv
// Bench for acc_flag_alu: vector table through a done-driven scoreboard, plus handshake,
// AF load and mid-operation reset sequences.
module tb_acc_flag_alu;
    import gb_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'h0;
    logic [7:0]  cmd_operand = 8'h00;
    logic        load_af_valid = 1'b0;
    logic        load_af_ready;
    logic [15:0] af_in = 16'h0000;
    logic [7:0]  a_out;
    logic [7:0]  f_out;
    logic        done;

    acc_flag_alu dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_operand   (cmd_operand),
        .load_af_valid (load_af_valid),
        .load_af_ready (load_af_ready),
        .af_in         (af_in),
        .a_out         (a_out),
        .f_out         (f_out),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] operand;
        logic [7:0] a;
        logic [7:0] f;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] f;
    } exp_t;

    localparam int NV = 25;
    vec_t vecs[NV];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_idx = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious done", {15'b0, done}, 16'h0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("done #%0d A/F", done_idx), {a_out, f_out}, {e.a, e.f});
                done_idx++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle in which done is visible.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] opnd,
                          input logic [7:0] ea, input logic [7:0] ef);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("cmd_ready timeout", {15'b0, cmd_ready}, 16'h0001);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = opnd;
        exp_q.push_back('{a: ea, f: ef});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{OP_LDA, 8'h3A, 8'h3A, 8'h00};
        vecs[1]  = '{OP_ADD, 8'hC6, 8'h00, 8'hB0};
        vecs[2]  = '{OP_LDA, 8'h15, 8'h15, 8'hB0};
        vecs[3]  = '{OP_ADD, 8'h27, 8'h3C, 8'h00};
        vecs[4]  = '{OP_DAA, 8'h00, 8'h42, 8'h00};
        vecs[5]  = '{OP_LDA, 8'h10, 8'h10, 8'h00};
        vecs[6]  = '{OP_SUB, 8'h01, 8'h0F, 8'h60};
        vecs[7]  = '{OP_DAA, 8'h00, 8'h09, 8'h40};
        vecs[8]  = '{OP_AND, 8'h0F, 8'h09, 8'h20};
        vecs[9]  = '{OP_XOR, 8'h09, 8'h00, 8'h80};
        vecs[10] = '{OP_OR,  8'h5A, 8'h5A, 8'h00};
        vecs[11] = '{OP_CP,  8'h5A, 8'h5A, 8'hC0};
        vecs[12] = '{OP_CP,  8'h5B, 8'h5A, 8'h70};
        vecs[13] = '{OP_ADC, 8'h05, 8'h60, 8'h20};
        vecs[14] = '{OP_SBC, 8'h60, 8'h00, 8'hC0};
        vecs[15] = '{OP_DEC, 8'h00, 8'hFF, 8'h60};
        vecs[16] = '{OP_CPL, 8'h00, 8'h00, 8'h60};
        vecs[17] = '{OP_SCF, 8'h00, 8'h00, 8'h10};
        vecs[18] = '{OP_SBC, 8'h00, 8'hFF, 8'h70};
        vecs[19] = '{OP_NOP, 8'h33, 8'hFF, 8'h70};
        vecs[20] = '{OP_ADC, 8'h00, 8'h00, 8'hB0};
        vecs[21] = '{OP_DAA, 8'h00, 8'h66, 8'h10};
        vecs[22] = '{OP_INC, 8'h00, 8'h67, 8'h10};
        vecs[23] = '{OP_LDA, 8'h0F, 8'h0F, 8'h10};
        vecs[24] = '{OP_INC, 8'h00, 8'h10, 8'h30};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset A/F", {a_out, f_out}, 16'h0000);
        check("reset done", {15'b0, done}, 16'h0000);
        check("reset cmd_ready", {15'b0, cmd_ready}, 16'h0001);
        check("reset load_af_ready", {15'b0, load_af_ready}, 16'h0001);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_cmd(vecs[i].op, vecs[i].operand, vecs[i].a, vecs[i].f);
        end

        // AF load, then flag-only ops and INC wrapping with carry preserved
        @(posedge clk); #1;
        load_af_valid = 1'b1;
        af_in         = 16'h12FF;
        @(posedge clk); #1;
        load_af_valid = 1'b0;
        @(negedge clk);
        check("load_af A/F", {a_out, f_out}, 16'h12F0);
        check("load_af no done", {15'b0, done}, 16'h0000);
        @(posedge clk); #1;
        do_cmd(OP_CCF, 8'h00, 8'h12, 8'h80);
        do_cmd(OP_SCF, 8'h00, 8'h12, 8'h90);
        do_cmd(OP_LDA, 8'hFF, 8'hFF, 8'h90);
        do_cmd(OP_INC, 8'h00, 8'h00, 8'hB0);

        // Handshake: cmd_valid held 4 cycles, load request in cycle 2
        @(posedge clk); #1;
        exp_q.push_back('{a: 8'h55, f: 8'hB0});
        cmd_valid   = 1'b1;
        cmd_op      = OP_LDA;
        cmd_operand = 8'h55;
        @(negedge clk);
        check("hs c0 cmd_ready", {15'b0, cmd_ready}, 16'h0001);
        @(posedge clk); #1;
        @(negedge clk);
        check("hs c1 cmd_ready", {15'b0, cmd_ready}, 16'h0000);
        check("hs c1 load_af_ready", {15'b0, load_af_ready}, 16'h0000);
        @(posedge clk); #1;
        load_af_valid = 1'b1;
        af_in         = 16'hA3C5;
        @(negedge clk);
        check("hs c2 done", {15'b0, done}, 16'h0001);
        check("hs c2 cmd_ready", {15'b0, cmd_ready}, 16'h0000);
        check("hs c2 load_af_ready", {15'b0, load_af_ready}, 16'h0001);
        @(posedge clk); #1;
        load_af_valid = 1'b0;
        @(negedge clk);
        check("hs c3 A/F after load", {a_out, f_out}, 16'hA3C0);
        check("hs c3 cmd_ready", {15'b0, cmd_ready}, 16'h0001);
        check("hs c3 no done", {15'b0, done}, 16'h0000);
        exp_q.push_back('{a: 8'h55, f: 8'hC0});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("hs c4 cmd_ready", {15'b0, cmd_ready}, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset during EXEC of ADD 0x01 with A=0x7F
        do_cmd(OP_LDA, 8'h7F, 8'h7F, 8'hC0);
        cmd_valid   = 1'b1;
        cmd_op      = OP_ADD;
        cmd_operand = 8'h01;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst mid-op A/F", {a_out, f_out}, 16'h0000);
        check("rst mid-op no done", {15'b0, done}, 16'h0000);
        check("rst mid-op cmd_ready", {15'b0, cmd_ready}, 16'h0001);
        @(posedge clk); #1;
        @(negedge clk);
        check("after rst no done", {15'b0, done}, 16'h0000);
        check("after rst A/F", {a_out, f_out}, 16'h0000);
        check("after rst cmd_ready", {15'b0, cmd_ready}, 16'h0001);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard drained", exp_q.size() > 0 ? 16'h0001 : 16'h0000, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_flag_alu.md
# acc_flag_alu

Accumulator/flag execution stage of the CPU core. It holds the A and F registers, accepts one 8-bit ALU command at a time from the micro-sequencer, and executes it over a fixed two-cycle cadence. It writes the result back to A/F and pulses completion. DAA correction is delegated to the existing `daa_mod` block; this stage feeds it A and the C/H/N flags and consumes its result and carry.

## Interface
- No parameters. Data width is fixed at 8; F layout is {Z,N,H,C,4'b0000}.
- clk  in  1  single core clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  stage can accept a command: state==IDLE && !load_af_valid
- cmd_op  in  4  opcode, encoded in gb_alu_pkg
- cmd_operand  in  8  B operand; the LDA data
- load_af_valid  in  1  direct AF load (POP AF); level, held until load_af_ready
- load_af_ready  out  1  state==IDLE
- af_in  in  16  {A, F}; F low nibble ignored
- a_out  out  8  registered A
- f_out  out  8  registered F; low nibble always 0
- done  out  1  one-cycle pulse: A/F now reflect the completed command

## Operation
- Opcodes:
  - ADD=0, ADC=1, SUB=2, SBC=3
  - AND=4, XOR=5, OR=6, CP=7
  - INC=8, DEC=9, DAA=A, CPL=B
  - SCF=C, CCF=D, LDA=E
  - F is reserved: executes as a NOP, A/F unchanged, done still pulses.
- Arithmetic and logic flag rules (r = 8-bit result, Z = (r==0)):
  - ADD/ADC: A+B(+C). H = carry out of bit 3; C = carry out of bit 7; N=0.
  - SUB/SBC: A−B(−C). N=1; H = borrow from bit 4, i.e. A[3:0] < B[3:0]+cin; C = borrow, i.e. 9-bit A < B+cin.
  - CP: same flags as SUB; A is unchanged.
  - AND: N=0, H=1, C=0.
  - XOR/OR: N=0, H=0, C=0.
- Unary and flag-only rules:
  - INC: A+1. N=0; H = (A[3:0]==F); C unchanged.
  - DEC: A−1. N=1; H = (A[3:0]==0); C unchanged.
  - DAA: A = daa out; Z = daa z_out; N unchanged; H=0; C = daa c_out.
  - CPL: A = ~A; N=1, H=1; Z and C unchanged.
  - SCF: N=0, H=0, C=1. CCF: N=0, H=0, C=~C. Z unchanged for both.
  - LDA: A = operand; F unchanged.
- Operands and priority:
  - Operands are latched at acceptance.
  - Flags are read from the F register at execution, so back-to-back dependent ops are always correct.
  - load_af has priority over cmd in IDLE. It writes A=af_in[15:8] and F={af_in[7:4],4'b0} at the next edge, with no done pulse.

## Timing
- Reset values: a_out=0x00, f_out=0x00, done=0, state=IDLE. cmd_ready=1 unless load_af_valid is high.
- FSM states are IDLE and EXEC.
- IDLE → EXEC on cmd_valid&&cmd_ready; op and operand are latched at that edge.
- EXEC → IDLE unconditionally. A/F are written at that edge and done is registered high.
- Latency for a command accepted at edge N:
  - EXEC occupies the cycle after N.
  - done=1 and the new a_out/f_out are visible in the cycle after N+1, which is the IDLE cycle.
- Throughput is one command per 2 cycles; cmd_ready is high again in the same cycle as done.
- load_af_valid during EXEC is not taken. load_af_ready=0; the caller holds the request, and it is taken in the following IDLE cycle.
- Simultaneous cmd_valid and load_af_valid in IDLE: the load wins and the command waits (cmd_ready=0).
- rst during EXEC: the command is abandoned, no done pulse, and all registers return to reset values.
- rst has priority over every other event.

## Structure
- gb_alu_pkg holds:
  - the opcode localparams
  - flag bit indices FLAG_Z=7, FLAG_N=6, FLAG_H=5, FLAG_C=4
- One sub-module instance: daa_mod. Its in, c_in, h_in and n_in inputs are driven from A and F. Its out, c_out and z_out outputs are used in EXEC for DAA.
- All other arithmetic is inline, using a 9-bit add/subtract for carry and separate nibble sums for H.

## Test plan
- Flag set on ADD: LDA 0x3A, then ADD 0xC6 → done pulse; A=0x00, F=0xB0.
- BCD add: LDA 0x15, ADD 0x27 → A=0x3C, F=0x00. Then DAA → A=0x42, F=0x00.
- BCD subtract: LDA 0x10, SUB 0x01 → A=0x0F, F=0x60. Then DAA → A=0x09, F=0x40.
- AF load and flag complement: load_af 0x12FF → A=0x12, F=0xF0, no done. Then CCF → F=0x80. Then INC with A forced to 0xFF via LDA and C previously set by SCF → A=0x00, F=0xB0.
- Handshake: hold cmd_valid high for 4 cycles with load_af_valid asserted in cycle 2.
  - Accept at cycle 0; done at cycle 2.
  - Load taken in cycle 2 with cmd_ready=0.
  - Next accept at cycle 3.
- Reset mid-op: assert rst in the EXEC cycle of ADD 0x01 with A=0x7F → no done; A=0x00, F=0x00; cmd_ready=1 the cycle after.
